program_loader: RTL and testbench

Boot-time instruction loader. It sits upstream of the instruction ROM/memory and the single-cycle core `top`. It receives a byte stream over a valid/ready link, assembles little-endian 32-bit words, and writes them to consecutive instruction-memory addresses from 0. It holds the core in reset until the whole image has been written and the checksum matches.

---
 rtl/program_loader.sv | 157 +++++++++++++++
 tb/tb_program_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time image loader. Receives a byte stream
// (2-byte word count, little-endian 32-bit words, 1 checksum byte), writes
// the words to instruction memory from address 0, and holds the core in reset
// until the full image has been written and the checksum has matched.
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RX_VALID,
  input  logic [7:0]            RX_DATA,
  output logic                  RX_READY,
  output logic                  IMEM_WE,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [SIZE-1:0]       IMEM_WDATA,
  output logic                  CORE_RESET_N,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_WIDTH:0]   WORDS_LOADED
);

  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Largest image that fits the instruction memory, widened so that
  // 2^ADDR_WIDTH itself is representable next to a 16-bit count.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                state_q;
  logic [15:0]           count_q;      // word count N from the header
  logic [1:0]            byte_cnt_q;   // byte position inside the current word
  logic [23:0]           shift_q;      // first three bytes of the current word
  logic [7:0]            sum_q;        // running payload checksum
  logic [ADDR_WIDTH:0]   words_q;      // words written so far
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [SIZE-1:0]       imem_wdata_q;
  logic                  rx_ready_q;
  logic                  done_q;
  logic                  error_q;
  logic                  core_rst_n_q;

  logic                  accept_d;
  logic [15:0]           n_d;
  logic                  n_too_big_d;
  logic [ADDR_WIDTH:0]   words_d;
  logic                  last_word_d;
  logic [31:0]           word_d;
  logic [7:0]            sum_d;

  // Helper values derived from the incoming byte and current state.
  always_comb begin
    accept_d    = RX_VALID && rx_ready_q;
    n_d         = {RX_DATA, count_q[7:0]};
    n_too_big_d = ({1'b0, n_d} > MAX_WORDS);
    words_d     = words_q + 1'b1;
    last_word_d = (16'(words_d) == count_q);
    // Little-endian: the byte arriving now is the most significant one.
    word_d      = {RX_DATA, shift_q};
    sum_d       = sum_q + RX_DATA;
  end

  // Loader FSM with all outputs registered; terminal states exit only on RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_HDR_LO;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      sum_q        <= '0;
      words_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      rx_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse.
      imem_we_q <= 1'b0;
      if (accept_d) begin
        case (state_q)
          S_HDR_LO: begin
            count_q[7:0] <= RX_DATA;
            state_q      <= S_HDR_HI;
          end
          S_HDR_HI: begin
            count_q <= n_d;
            if (n_too_big_d) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end else if (n_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            sum_q      <= sum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {RX_DATA, shift_q[23:8]};
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              // N <= 2^ADDR_WIDTH, so truncating the index never aliases.
              imem_addr_q  <= words_q[ADDR_WIDTH-1:0];
              imem_wdata_q <= word_d;
              words_q      <= words_d;
              if (last_word_d) begin
                state_q <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (RX_DATA == sum_q) begin
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
              rx_ready_q   <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          S_ERR: begin
            // Bytes keep being accepted and are dropped.
            state_q <= S_ERR;
          end
          default: begin
            state_q <= S_ERR;
            error_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign RX_READY     = rx_ready_q;
  assign IMEM_WE      = imem_we_q;
  assign IMEM_ADDR    = imem_addr_q;
  assign IMEM_WDATA   = imem_wdata_q;
  assign CORE_RESET_N = core_rst_n_q;
  assign DONE         = done_q;
  assign ERROR        = error_q;
  assign WORDS_LOADED = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a byte-history model derives every output from the
// stream rules and is checked each cycle, plus literal checks per scenario.
module tb_program_loader;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          RX_VALID = 1'b0;
  logic [7:0]    RX_DATA = 8'h00;
  logic          RX_READY;
  logic          IMEM_WE;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_WDATA;
  logic          CORE_RESET_N;
  logic          DONE;
  logic          ERROR;
  logic [AW:0]   WORDS_LOADED;

  always #5 CLK = ~CLK;

  program_loader #(.ADDR_WIDTH(AW), .SIZE(32)) dut (
    .CLK(CLK), .RESET(RESET), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .RX_READY(RX_READY), .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_WDATA(IMEM_WDATA), .CORE_RESET_N(CORE_RESET_N), .DONE(DONE),
    .ERROR(ERROR), .WORDS_LOADED(WORDS_LOADED)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: everything follows from accepted bytes ----------
  logic [7:0]  hist[$];
  bit          mvalid = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  function automatic int m_n();
    return int'({hist[1], hist[0]});
  endfunction

  function automatic bit m_over();
    return (hist.size() >= 2) && (m_n() > (1 << AW));
  endfunction

  function automatic int m_words_at(int sz);
    int w;
    if (sz < 6) return 0;
    if (m_over()) return 0;
    w = (sz - 2) / 4;
    return (w < m_n()) ? w : m_n();
  endfunction

  function automatic bit m_chk_seen();
    if (hist.size() < 2 || m_over()) return 0;
    return hist.size() >= 3 + 4 * m_n();
  endfunction

  function automatic bit m_sum_ok();
    int s = 0;
    for (int i = 0; i < 4 * m_n(); i++) s += int'(hist[2 + i]);
    return (s % 256) == int'(hist[2 + 4 * m_n()]);
  endfunction

  function automatic bit m_done();
    return m_chk_seen() && m_sum_ok();
  endfunction

  function automatic bit m_err();
    return m_over() || (m_chk_seen() && !m_sum_ok());
  endfunction

  always @(posedge CLK) begin : model_upd
    int before_w;
    int after_w;
    int base;
    if (RESET) begin
      hist.delete();
      mvalid    <= 1;
      exp_we    <= 1'b0;
      exp_addr  <= '0;
      exp_wdata <= '0;
    end else if (mvalid) begin
      exp_we <= 1'b0;
      if (RX_VALID && !m_done()) begin
        before_w = m_words_at(hist.size());
        after_w  = m_words_at(hist.size() + 1);
        if (after_w > before_w) begin
          base = 2 + 4 * (after_w - 1);
          exp_we    <= 1'b1;
          exp_addr  <= 32'(after_w - 1);
          exp_wdata <= {RX_DATA, hist[base + 2], hist[base + 1], hist[base]};
        end
        hist.push_back(RX_DATA);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (mvalid) begin
      chk("cyc_rx_ready",  32'(RX_READY),     32'(!m_done()));
      chk("cyc_imem_we",   32'(IMEM_WE),      32'(exp_we));
      chk("cyc_imem_addr", 32'(IMEM_ADDR),    exp_addr);
      chk("cyc_imem_wdata", IMEM_WDATA,       exp_wdata);
      chk("cyc_core_rst_n", 32'(CORE_RESET_N), 32'(m_done()));
      chk("cyc_done",      32'(DONE),         32'(m_done()));
      chk("cyc_error",     32'(ERROR),        32'(m_err()));
      chk("cyc_words",     32'(WORDS_LOADED), 32'(m_words_at(hist.size())));
    end
  end

  // Observed write log for the literal checks.
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  always @(negedge CLK) begin
    if (IMEM_WE === 1'b1) begin
      wlog_addr.push_back(32'(IMEM_ADDR));
      wlog_data.push_back(IMEM_WDATA);
      $display("write addr=%0d data=%h", IMEM_ADDR, IMEM_WDATA);
    end
  end

  function automatic logic [31:0] wa(int i);
    return (wlog_addr.size() > i) ? wlog_addr[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wd(int i);
    return (wlog_data.size() > i) ? wlog_data[i] : 32'hDEAD_BEEF;
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK); #1;
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK); #1;
    RX_VALID = 1'b1;
    RX_DATA  = b;
    $display("byte %h", b);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send(s[i]);
    end
    idle(1);
  endtask

  // One reset cycle, with a byte offered at the same time (reset wins).
  task automatic do_reset();
    @(negedge CLK); #1;
    RESET = 1'b1;
    RX_VALID = 1'b1;
    RX_DATA = 8'($urandom);
    @(negedge CLK); #1;
    RESET = 1'b0;
    RX_VALID = 1'b0;
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  logic [7:0] s[$];

  initial begin
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    #1 RESET = 1'b0;
    // Reset values
    chk("rst_ready", 32'(RX_READY), 32'd1);
    chk("rst_we",    32'(IMEM_WE), 32'd0);
    chk("rst_addr",  32'(IMEM_ADDR), 32'd0);
    chk("rst_wdata", IMEM_WDATA, 32'd0);
    chk("rst_crn",   32'(CORE_RESET_N), 32'd0);
    chk("rst_done",  32'(DONE), 32'd0);
    chk("rst_err",   32'(ERROR), 32'd0);
    chk("rst_words", 32'(WORDS_LOADED), 32'd0);

    // Nominal, continuous
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_stream(s, 0);
    chk("nom_nwrites", 32'(wlog_addr.size()), 32'd2);
    chk("nom_a0", wa(0), 32'd0);
    chk("nom_d0", wd(0), 32'h0000_0013);
    chk("nom_a1", wa(1), 32'd1);
    chk("nom_d1", wd(1), 32'h0010_0093);
    chk("nom_words", 32'(WORDS_LOADED), 32'd2);
    chk("nom_done", 32'(DONE), 32'd1);
    chk("nom_crn", 32'(CORE_RESET_N), 32'd1);
    chk("nom_ready", 32'(RX_READY), 32'd0);
    chk("nom_model_words", 32'(m_words_at(hist.size())), 32'd2);
    idle(2);

    // Checksum mismatch
    do_reset();
    s[10] = 8'hB7;
    send_stream(s, 0);
    chk("bad_nwrites", 32'(wlog_addr.size()), 32'd2);
    chk("bad_d1", wd(1), 32'h0010_0093);
    chk("bad_err", 32'(ERROR), 32'd1);
    chk("bad_done", 32'(DONE), 32'd0);
    chk("bad_crn", 32'(CORE_RESET_N), 32'd0);
    chk("bad_ready", 32'(RX_READY), 32'd1);
    chk("bad_model_err", 32'(m_err()), 32'd1);
    idle(2);

    // Empty image
    do_reset();
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 0);
    chk("empty_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("empty_words", 32'(WORDS_LOADED), 32'd0);
    chk("empty_done", 32'(DONE), 32'd1);
    chk("empty_crn", 32'(CORE_RESET_N), 32'd1);
    idle(2);

    // Oversize N=1025, then trailing bytes discarded
    do_reset();
    s = '{8'h01, 8'h04};
    send_stream(s, 0);
    chk("over_err", 32'(ERROR), 32'd1);
    chk("over_ready", 32'(RX_READY), 32'd1);
    s = '{8'hAA, 8'h55, 8'h00, 8'h11, 8'h22};
    send_stream(s, 0);
    chk("over_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("over_words", 32'(WORDS_LOADED), 32'd0);
    chk("over_err2", 32'(ERROR), 32'd1);
    chk("over_done", 32'(DONE), 32'd0);

    // Boundary N=1024 is accepted
    do_reset();
    s = '{8'h00, 8'h04};
    send_stream(s, 0);
    chk("max_err", 32'(ERROR), 32'd0);
    chk("max_ready", 32'(RX_READY), 32'd1);
    chk("max_done", 32'(DONE), 32'd0);

    // Nominal with bubbles
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_stream(s, 5);
    chk("bub_nwrites", 32'(wlog_addr.size()), 32'd2);
    chk("bub_d0", wd(0), 32'h0000_0013);
    chk("bub_a1", wa(1), 32'd1);
    chk("bub_d1", wd(1), 32'h0010_0093);
    chk("bub_done", 32'(DONE), 32'd1);
    idle(2);

    // Reset mid-word
    do_reset();
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_stream(s, 0);
    chk("mid_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("mid_words", 32'(WORDS_LOADED), 32'd0);
    do_reset();
    chk("mid_rst_words", 32'(WORDS_LOADED), 32'd0);
    chk("mid_rst_ready", 32'(RX_READY), 32'd1);
    s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    send_stream(s, 0);
    chk("mid_nwrites2", 32'(wlog_addr.size()), 32'd1);
    chk("mid_a0", wa(0), 32'd0);
    chk("mid_d0", wd(0), 32'h1234_5678);
    chk("mid_done", 32'(DONE), 32'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
